alu_operand_stage: RTL and testbench

Register-file and sequencing stage directly upstream of the 32-bit ALU; owns the flags fed back into it. Accepts one register-to-register instruction per handshake and reads two source registers. Drives the ALU's ina, inb, aluc and cin from registered values, then writes the ALU result and flags back. Two-cycle, non-pipelined, single-issue.

---
 rtl/alu_operand_stage_if.sv | 31 +++
 rtl/alu_operand_stage.sv | 98 +++++++++
 tb/tb_alu_operand_stage.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_if.sv
// Instruction handshake plus the operand/result bus to the 32-bit ALU.
// The stage uses the slave modport; the instruction source/ALU side uses master.
interface alu_operand_stage_if #(
   parameter int AW = 3
);
   logic          instr_valid;
   logic          instr_ready;
   logic [3:0]    instr_op;
   logic [AW-1:0] instr_ra;
   logic [AW-1:0] instr_rb;
   logic [AW-1:0] instr_rd;
   logic [31:0]   ina;
   logic [31:0]   inb;
   logic [3:0]    aluc;
   logic          cin;
   logic [31:0]   alu_out;
   logic          alu_cout;
   logic          alu_ovf;

   modport master (
      output instr_valid, instr_op, instr_ra, instr_rb, instr_rd,
      output alu_out, alu_cout, alu_ovf,
      input  instr_ready, ina, inb, aluc, cin
   );

   modport slave (
      input  instr_valid, instr_op, instr_ra, instr_rb, instr_rd,
      input  alu_out, alu_cout, alu_ovf,
      output instr_ready, ina, inb, aluc, cin
   );
endinterface

// File: rtl/alu_operand_stage.sv
// Register file and two-cycle sequencer feeding the 32-bit ALU: read operands in IDLE,
// write back the ALU result and carry/overflow flags at the end of EXEC.
module alu_operand_stage #(
   parameter int AW      = 3,
   parameter bit R0_ZERO = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   alu_operand_stage_if.slave bus,
   output logic               carry_flag,
   output logic               ovf_flag,
   output logic               done,
   output logic               err,
   input  logic [AW-1:0]      dbg_addr,
   output logic [31:0]        dbg_data
);

   localparam int NREG = 1 << AW;

   typedef enum logic {IDLE, EXEC} state_t;

   state_t        state, state_nxt;
   logic [31:0]   rf [NREG];
   logic [31:0]   ina_q, inb_q;
   logic [3:0]    aluc_q;
   logic [AW-1:0] rd_q;
   logic          accept, retire, legal, flag_op, wr_en;

   function automatic logic [31:0] rf_read(input logic [AW-1:0] a);
      return (R0_ZERO && (a == '0)) ? 32'h0 : rf[a];
   endfunction

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt       = state;
      accept          = 1'b0;
      retire          = 1'b0;
      bus.instr_ready = 1'b0;
      case (state)
         IDLE: begin
            bus.instr_ready = 1'b1;
            if (bus.instr_valid) begin
               accept    = 1'b1;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            retire    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // aluc holds the op of the instruction in flight, so decode it from there.
   assign legal   = (aluc_q <= 4'b1010);
   assign flag_op = (aluc_q == 4'b0100) || (aluc_q == 4'b0101);
   assign wr_en   = retire && legal && !(R0_ZERO && (rd_q == '0));

   // NOTE: the register file is cleared by reset because software relies on every
   // register reading 0 after reset; this makes it flops, not an inferred RAM.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
         ina_q      <= '0;
         inb_q      <= '0;
         aluc_q     <= '0;
         rd_q       <= '0;
         carry_flag <= 1'b0;
         ovf_flag   <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= retire;
         err   <= retire && !legal;
         if (accept) begin
            aluc_q <= bus.instr_op;
            ina_q  <= rf_read(bus.instr_ra);
            inb_q  <= rf_read(bus.instr_rb);
            rd_q   <= bus.instr_rd;
         end
         if (wr_en) rf[rd_q] <= bus.alu_out;
         if (retire && flag_op) begin
            carry_flag <= bus.alu_cout;
            ovf_flag   <= bus.alu_ovf;
         end
      end
   end

   assign bus.ina  = ina_q;
   assign bus.inb  = inb_q;
   assign bus.aluc = aluc_q;
   assign bus.cin  = carry_flag;
   assign dbg_data = rf_read(dbg_addr);

endmodule

// File: tb/tb_alu_operand_stage.sv
// Table-driven bench for alu_operand_stage with a stand-in ALU and a retire scoreboard.
module tb_alu_operand_stage;

   localparam int AW = 3;

   typedef struct {
      logic [3:0]    op;
      logic [AW-1:0] ra, rb, rd;
      logic [31:0]   exp_rd;
      logic          carry, ovf, err;
   } vec_t;

   typedef struct {
      logic carry, ovf, err;
   } sb_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          carry_flag, ovf_flag, done, err;
   logic [AW-1:0] dbg_addr = '0;
   logic [31:0]   dbg_data;
   logic [32:0]   alu_sum;

   int n_vec = 0;
   int n_miss = 0;
   int cyc = 0;

   sb_t         sb[$];
   logic [31:0] ref_rf [8];
   logic        ref_c, ref_o;
   vec_t        vecs [12];
   vec_t        b2b  [4];
   int          acc_cyc [4];

   alu_operand_stage_if #(.AW(AW)) bus ();

   alu_operand_stage #(.AW(AW), .R0_ZERO(1'b1)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus.slave),
      .carry_flag (carry_flag),
      .ovf_flag   (ovf_flag),
      .done       (done),
      .err        (err),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in ALU: non-add ops report cout=ovf=1 so a leaking flag update shows up.
   always_comb begin
      alu_sum      = '0;
      bus.alu_cout = 1'b1;
      bus.alu_ovf  = 1'b1;
      bus.alu_out  = bus.ina ^ bus.inb;
      case (bus.aluc)
         4'b0011: bus.alu_out = bus.ina - bus.inb;
         4'b0100, 4'b0101: begin
            alu_sum      = {1'b0, bus.ina} + {1'b0, bus.inb} +
                           {32'h0, (bus.aluc == 4'b0101) ? bus.cin : 1'b0};
            bus.alu_out  = alu_sum[31:0];
            bus.alu_cout = alu_sum[32];
            bus.alu_ovf  = (bus.ina[31] == bus.inb[31]) && (alu_sum[31] != bus.ina[31]);
         end
         4'b0110: bus.alu_out = bus.ina >> 1;
         4'b1001: bus.alu_out = bus.ina + 32'd1;
         4'b1010: bus.alu_out = ~(bus.ina | bus.inb);
         default: ;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Retire monitor: pops the scoreboard on every done pulse.
   logic prev_done = 1'b0;
   logic prev_ready = 1'b1;
   int   low_run = 0;
   always @(negedge clk) begin
      if (!reset) begin
         if (done) begin
            check("done_width", prev_done, 0);
            check("sb_nonempty_at_done", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               sb_t e;
               e = sb.pop_front();
               check("err_at_done", err, e.err);
               check("carry_flag", carry_flag, e.carry);
               check("ovf_flag", ovf_flag, e.ovf);
            end
         end else if (err) begin
            check("err_without_done", err, 0);
         end
         if (bus.instr_ready === 1'b1 && prev_ready === 1'b0) check("ready_low_width", low_run, 1);
         low_run    = (bus.instr_ready === 1'b0) ? low_run + 1 : 0;
         prev_ready = bus.instr_ready;
         prev_done  = done;
      end
   end

   task automatic ref_clear();
      for (int i = 0; i < 8; i++) ref_rf[i] = '0;
      ref_c = 1'b0;
      ref_o = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int w;
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.instr_op    = v.op;
      bus.instr_ra    = v.ra;
      bus.instr_rb    = v.rb;
      bus.instr_rd    = v.rd;
      w = 0;
      while (!bus.instr_ready && w < 8) begin @(negedge clk); w++; end
      check("ready_before_accept", bus.instr_ready, 1);
      sb.push_back('{carry: v.carry, ovf: v.ovf, err: v.err});
      @(posedge clk);
      #1 bus.instr_valid = 1'b0;
      @(negedge clk);
      check("ready_in_exec", bus.instr_ready, 0);
      check("ina", bus.ina, ref_rf[v.ra]);
      check("inb", bus.inb, ref_rf[v.rb]);
      check("aluc", bus.aluc, v.op);
      check("cin", bus.cin, ref_c);
      w = 0;
      while (!done && w < 8) begin @(negedge clk); w++; end
      check("done_seen", done, 1);
      ref_rf[v.rd] = v.exp_rd;
      ref_c        = v.carry;
      ref_o        = v.ovf;
      dbg_addr     = v.rd;
      #1 check("dbg_rd", dbg_data, v.exp_rd);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      //          op       ra rb rd  exp_rd        c     o     e
      vecs[0]  = '{4'b1010, 0, 0, 1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{4'b1001, 0, 0, 2, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{4'b0100, 1, 2, 3, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{4'b0101, 2, 2, 4, 32'h0000_0003, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{4'b1010, 0, 0, 0, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{4'b1101, 1, 2, 5, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
      vecs[6]  = '{4'b0110, 1, 0, 6, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{4'b0100, 6, 2, 7, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{4'b0100, 7, 7, 7, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{4'b0101, 4, 1, 5, 32'h0000_0003, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{4'b0010, 4, 2, 6, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{4'b1111, 4, 4, 4, 32'h0000_0003, 1'b1, 1'b0, 1'b1};

      b2b[0] = '{4'b1010, 0, 0, 1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
      b2b[1] = '{4'b0110, 1, 0, 2, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0};
      b2b[2] = '{4'b1001, 2, 0, 3, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
      b2b[3] = '{4'b0100, 3, 3, 4, 32'h0000_0000, 1'b1, 1'b1, 1'b0};

      bus.instr_valid = 1'b0;
      bus.instr_op    = '0;
      bus.instr_ra    = '0;
      bus.instr_rb    = '0;
      bus.instr_rd    = '0;
      ref_clear();

      // Reset state
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_ready", bus.instr_ready, 1);
      check("rst_carry", carry_flag, 0);
      check("rst_ovf", ovf_flag, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_ina", bus.ina, 0);
      check("rst_inb", bus.inb, 0);
      check("rst_aluc", bus.aluc, 0);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = AW'(i);
         #1 check("rst_dbg", dbg_data, 0);
      end

      // Main vector table
      for (int i = 0; i < 12; i++) run_vec(vecs[i]);

      // Reset during EXEC of op 1001 rd=r6 aborts the writeback
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.instr_op    = 4'b1001;
      bus.instr_ra    = 3'd4;
      bus.instr_rb    = 3'd0;
      bus.instr_rd    = 3'd6;
      check("abort_ready_before", bus.instr_ready, 1);
      @(posedge clk);
      #1 bus.instr_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      ref_clear();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_no_done", done, 0);
         check("abort_ready", bus.instr_ready, 1);
      end
      dbg_addr = 3'd6;
      #1 check("abort_r6", dbg_data, 0);
      check("abort_carry", carry_flag, 0);

      // Back-to-back with valid held high; second reads first's rd
      @(negedge clk);
      bus.instr_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         int w;
         bus.instr_op = b2b[k].op;
         bus.instr_ra = b2b[k].ra;
         bus.instr_rb = b2b[k].rb;
         bus.instr_rd = b2b[k].rd;
         sb.push_back('{carry: b2b[k].carry, ovf: b2b[k].ovf, err: b2b[k].err});
         w = 0;
         while (!bus.instr_ready && w < 8) begin @(negedge clk); w++; end
         check("b2b_ready", bus.instr_ready, 1);
         @(posedge clk);
         #1 acc_cyc[k] = cyc;
      end
      bus.instr_valid = 1'b0;
      for (int k = 1; k < 4; k++) check("b2b_accept_spacing", acc_cyc[k] - acc_cyc[k-1], 2);
      repeat (4) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         dbg_addr = b2b[k].rd;
         #1 check("b2b_dbg", dbg_data, b2b[k].exp_rd);
      end
      check("b2b_carry", carry_flag, 1);
      check("b2b_ovf", ovf_flag, 1);

      repeat (2) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
